// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache miss/writeback traffic onto a single RAM port.
// dcache wins by default; a starvation counter forces an icache grant periodically.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DSERVE = 2'd1,
        ISERVE = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_reg;
    state_t      state_next;
    logic [3:0]  starve_cnt_reg;
    logic [3:0]  starve_cnt_next;
    logic        d_req;
    logic        ram_done;

    assign d_req    = dREN | dWEN;
    assign ram_done = (ramstate == RAM_ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= 4'd0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // Outputs are decoded from the registered state plus live inputs, so a
    // withdrawn request drops the RAM enables in the same cycle.
    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        ramREN          = 1'b0;
        ramWEN          = 1'b0;
        ramaddr         = 32'd0;
        ramstore        = 32'd0;
        iwait           = 1'b1;
        iload           = 32'd0;
        dwait           = 1'b1;
        dload           = 32'd0;

        case (state_reg)
            IDLE: begin
                if (d_req && !(iREN && (starve_cnt_reg == STARVE_LIM))) begin
                    state_next = DSERVE;
                end else if (iREN) begin
                    state_next = ISERVE;
                end
            end

            DSERVE: begin
                if (!d_req) begin
                    state_next = IDLE;
                end else begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    if (ram_done) begin
                        dwait      = 1'b0;
                        dload      = ramload;
                        state_next = IDLE;
                        if (!iREN) begin
                            starve_cnt_next = 4'd0;
                        end else if (starve_cnt_reg < STARVE_LIM) begin
                            starve_cnt_next = starve_cnt_reg + 4'd1;
                        end
                    end
                end
            end

            ISERVE: begin
                if (!iREN) begin
                    state_next = IDLE;
                end else begin
                    ramaddr = iaddr;
                    ramREN  = 1'b1;
                    if (ram_done) begin
                        iwait           = 1'b0;
                        iload           = ramload;
                        state_next      = IDLE;
                        starve_cnt_next = 4'd0;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// compared cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;
    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the RAM port (0 none, 1 dcache, 2 icache)
    // and how many dcache grants in a row have overtaken a waiting icache.
    int m_owner  = 0;
    int m_starve = 0;

    logic        e_ren, e_wen, e_iwait, e_dwait;
    logic [31:0] e_addr, e_store, e_iload, e_dload;

    int grants[$];

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic model_edge();
        bit d_req;
        bit done;
        d_req = dREN || dWEN;
        done  = (ramstate == RS_ACCESS);
        if (!nRST) begin
            m_owner  = 0;
            m_starve = 0;
        end else if (m_owner == 0) begin
            if (d_req && !(iREN && m_starve == STARVE_MAX)) m_owner = 1;
            else if (iREN) m_owner = 2;
        end else if (m_owner == 1) begin
            if (!d_req) m_owner = 0;
            else if (done) begin
                m_owner  = 0;
                m_starve = iREN ? ((m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1) : 0;
            end
        end else begin
            if (!iREN) m_owner = 0;
            else if (done) begin
                m_owner  = 0;
                m_starve = 0;
            end
        end
    endtask

    task automatic model_outputs();
        bit done;
        done    = (ramstate == RS_ACCESS);
        e_ren   = 1'b0; e_wen = 1'b0; e_addr = 32'd0; e_store = 32'd0;
        e_iwait = 1'b1; e_dwait = 1'b1; e_iload = 32'd0; e_dload = 32'd0;
        if (m_owner == 1 && (dREN || dWEN)) begin
            e_addr  = daddr;
            e_store = dstore;
            e_wen   = dWEN;
            e_ren   = dREN && !dWEN;
            e_dwait = !done;
            e_dload = done ? ramload : 32'd0;
        end else if (m_owner == 2 && iREN) begin
            e_addr  = iaddr;
            e_ren   = 1'b1;
            e_iwait = !done;
            e_iload = done ? ramload : 32'd0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0;
        ramload = 0; ramstate = RS_FREE;
    endtask

    task automatic test_reset();
        clear_inputs();
        nRST = 0;
        tick();
        tick();
        n_checks++;
        if ({ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload} !== {1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_hold: ren=%b wen=%b addr=%h store=%h iwait=%b dwait=%b, required 0 0 0 0 1 1", ramREN, ramWEN, ramaddr, ramstore, iwait, dwait);
        end
        nRST = 1;
        tick();
        n_checks++;
        if ({ramREN, ramWEN, ramaddr, iwait, dwait} !== {1'b0, 1'b0, 32'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_release: ren=%b wen=%b addr=%h iwait=%b dwait=%b, required idle", ramREN, ramWEN, ramaddr, iwait, dwait);
        end
        $display("txn reset done");
    endtask

    task automatic test_single_iread();
        iREN = 1; iaddr = 32'h100;
        tick();
        ramstate = RS_BUSY;
        for (int c = 1; c <= 2; c++) begin
            #1;
            n_checks++;
            if ({ramREN, ramWEN, ramaddr, iwait} !== {1'b1, 1'b0, 32'h100, 1'b1}) begin
                n_fail++;
                $display("FAIL iread_busy%0d: ren=%b wen=%b addr=%h iwait=%b, required 1 0 100 1", c, ramREN, ramWEN, ramaddr, iwait);
            end
            tick();
        end
        ramstate = RS_ACCESS; ramload = 32'hDEADBEEF;
        #1;
        n_checks++;
        if ({iwait, iload, dwait} !== {1'b0, 32'hDEADBEEF, 1'b1}) begin
            n_fail++;
            $display("FAIL iread_access: iwait=%b iload=%h dwait=%b, required 0 deadbeef 1", iwait, iload, dwait);
        end
        tick();
        ramstate = RS_FREE;
        #1;
        n_checks++;
        if ({ramREN, iwait} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL iread_bubble: ren=%b iwait=%b, required 0 1", ramREN, iwait);
        end
        $display("txn icache read addr=%h data=deadbeef", iaddr);
        clear_inputs();
        tick();
    endtask

    task automatic test_simultaneous();
        iREN = 1; iaddr = 32'h300;
        dWEN = 1; daddr = 32'h200; dstore = 32'h12345678;
        tick();
        ramstate = RS_BUSY;
        #1;
        n_checks++;
        if ({ramWEN, ramREN, ramaddr, ramstore, dwait, iwait} !== {1'b1, 1'b0, 32'h200, 32'h12345678, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL simul_dserve: wen=%b ren=%b addr=%h store=%h dwait=%b iwait=%b, required 1 0 200 12345678 1 1", ramWEN, ramREN, ramaddr, ramstore, dwait, iwait);
        end
        tick();
        ramstate = RS_ACCESS;
        #1;
        n_checks++;
        if ({dwait, iwait} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL simul_dcomplete: dwait=%b iwait=%b, required 0 1", dwait, iwait);
        end
        $display("txn dcache write addr=%h data=%h", daddr, dstore);
        tick();
        dWEN = 0; ramstate = RS_FREE;
        #1;
        n_checks++;
        if ({ramREN, ramWEN, iwait, dwait} !== {1'b0, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL simul_bubble: ren=%b wen=%b iwait=%b dwait=%b, required 0 0 1 1", ramREN, ramWEN, iwait, dwait);
        end
        tick();
        ramstate = RS_BUSY;
        #1;
        n_checks++;
        if ({ramREN, ramWEN, ramaddr, ramstore} !== {1'b1, 1'b0, 32'h300, 32'd0}) begin
            n_fail++;
            $display("FAIL simul_iserve: ren=%b wen=%b addr=%h store=%h, required 1 0 300 0", ramREN, ramWEN, ramaddr, ramstore);
        end
        tick();
        ramstate = RS_ACCESS; ramload = 32'hCAFEF00D;
        #1;
        n_checks++;
        if ({iwait, iload, dwait} !== {1'b0, 32'hCAFEF00D, 1'b1}) begin
            n_fail++;
            $display("FAIL simul_icomplete: iwait=%b iload=%h dwait=%b, required 0 cafef00d 1", iwait, iload, dwait);
        end
        $display("txn icache read addr=%h data=%h", iaddr, ramload);
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_starvation();
        string seq;
        iREN = 1; iaddr = 32'hA00;
        dREN = 1; daddr = 32'hB00;
        ramstate = RS_ACCESS; ramload = 32'h5A5A5A5A;
        grants.delete();
        for (int c = 0; c < 40 && grants.size() < 6; c++) begin
            if (ramREN && ramaddr == 32'hB00) grants.push_back(1);
            else if (ramREN && ramaddr == 32'hA00) grants.push_back(2);
            if (grants.size() < 6) tick();
        end
        seq = "";
        foreach (grants[k]) seq = {seq, (grants[k] == 1) ? "D" : "I"};
        n_checks++;
        if (seq != "DDDDID") begin
            n_fail++;
            $display("FAIL starvation_order: grant sequence %s, required DDDDID", seq);
        end
        $display("txn starvation grant sequence %s", seq);
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_withdraw();
        dREN = 1; daddr = 32'h440;
        tick();
        ramstate = RS_BUSY;
        #1;
        n_checks++;
        if ({ramREN, ramaddr} !== {1'b1, 32'h440}) begin
            n_fail++;
            $display("FAIL withdraw_granted: ren=%b addr=%h, required 1 440", ramREN, ramaddr);
        end
        dREN = 0;
        #1;
        n_checks++;
        if ({ramREN, ramWEN, dwait} !== {1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL withdraw_drop: ren=%b wen=%b dwait=%b, required 0 0 1", ramREN, ramWEN, dwait);
        end
        tick();
        dREN = 1; ramstate = RS_ACCESS;
        #1;
        n_checks++;
        if ({ramREN, dwait} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL withdraw_idle: ren=%b dwait=%b, required 0 1 (idle after withdrawal)", ramREN, dwait);
        end
        $display("txn dcache read withdrawn addr=%h", daddr);
        clear_inputs();
        tick();
    endtask

    task automatic test_error();
        int pulses;
        bit stable;
        pulses = 0; stable = 1;
        dREN = 1; daddr = 32'h880;
        tick();
        ramstate = RS_ERROR;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (!(ramREN && !ramWEN && ramaddr == 32'h880)) stable = 0;
            if (!dwait) pulses++;
            tick();
        end
        ramstate = RS_ACCESS; ramload = 32'h0BADF00D;
        #1;
        if (!(ramREN && ramaddr == 32'h880)) stable = 0;
        if (!dwait) pulses++;
        n_checks++;
        if (dload !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL error_data: dload=%h, required 0badf00d", dload);
        end
        tick();
        dREN = 0; ramstate = RS_FREE;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (!dwait) pulses++;
            tick();
        end
        n_checks++;
        if (!stable || pulses != 1) begin
            n_fail++;
            $display("FAIL error_retry: stable=%0d pulses=%0d, required stable=1 pulses=1", stable, pulses);
        end
        $display("txn dcache read after error addr=%h data=%h", daddr, 32'h0BADF00D);
    endtask

    task automatic test_reset_mid();
        int dg;
        string seq;
        dg = 0;
        iREN = 1; iaddr = 32'h600;
        dWEN = 1; daddr = 32'h500; dstore = 32'h77;
        ramstate = RS_ACCESS;
        for (int c = 0; c < 30; c++) begin
            if (ramWEN) dg++;
            if (dg == 3) break;
            tick();
        end
        ramstate = RS_BUSY;
        tick();
        tick();
        n_checks++;
        if ({ramWEN, ramaddr} !== {1'b1, 32'h500}) begin
            n_fail++;
            $display("FAIL rstmid_granted: wen=%b addr=%h dg=%0d, required 1 500", ramWEN, ramaddr, dg);
        end
        #2 nRST = 0;
        #1;
        n_checks++;
        if ({ramWEN, ramREN, ramaddr, dwait, iwait} !== {1'b0, 1'b0, 32'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL rstmid_async: wen=%b ren=%b addr=%h dwait=%b iwait=%b, required 0 0 0 1 1", ramWEN, ramREN, ramaddr, dwait, iwait);
        end
        tick();
        tick();
        nRST = 1;
        ramstate = RS_ACCESS;
        grants.delete();
        for (int c = 0; c < 30 && grants.size() < 5; c++) begin
            if (ramWEN) grants.push_back(1);
            else if (ramREN) grants.push_back(2);
            if (grants.size() < 5) tick();
        end
        seq = "";
        foreach (grants[k]) seq = {seq, (grants[k] == 1) ? "D" : "I"};
        n_checks++;
        if (seq != "DDDDI") begin
            n_fail++;
            $display("FAIL rstmid_counter: grant sequence %s, required DDDDI", seq);
        end
        $display("txn reset mid-access, post-reset grants %s", seq);
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_random();
        int r;
        clear_inputs();
        nRST = 0;
        tick();
        nRST = 1;
        tick();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 9) < 2) iREN = ~iREN;
            if ($urandom_range(0, 9) < 2) dREN = ~dREN;
            if ($urandom_range(0, 9) < 1) dWEN = ~dWEN;
            iaddr   = $urandom;
            daddr   = $urandom;
            dstore  = $urandom;
            ramload = $urandom;
            r = $urandom_range(0, 9);
            ramstate = (r < 4) ? RS_BUSY : (r < 7) ? RS_ACCESS : (r < 8) ? RS_ERROR : RS_FREE;
            #1;
            model_outputs();
            n_checks++;
            if ({ramREN, ramWEN, ramaddr, ramstore, iwait, iload, dwait, dload} !==
                {e_ren, e_wen, e_addr, e_store, e_iwait, e_iload, e_dwait, e_dload}) begin
                n_fail++;
                $display("FAIL random_c%0d: got ren=%b wen=%b addr=%h store=%h iw=%b il=%h dw=%b dl=%h, required ren=%b wen=%b addr=%h store=%h iw=%b il=%h dw=%b dl=%h",
                         c, ramREN, ramWEN, ramaddr, ramstore, iwait, iload, dwait, dload,
                         e_ren, e_wen, e_addr, e_store, e_iwait, e_iload, e_dwait, e_dload);
            end
            n_checks++;
            if (!iwait && !dwait) begin
                n_fail++;
                $display("FAIL random_waits_c%0d: iwait=%b dwait=%b, required not both 0", c, iwait, dwait);
            end
            if (!e_dwait) $display("txn random dcache %s addr=%h", dWEN ? "write" : "read", daddr);
            if (!e_iwait) $display("txn random icache read addr=%h data=%h", iaddr, ramload);
            tick();
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_iread();
        test_simultaneous();
        test_starvation();
        test_withdraw();
        test_error();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
